ab_trace_monitor: RTL

Downstream observer for the two-flip-flop x/y sequential stage: samples that stage's state outputs A and B every enabled clock, and tracks how the state evolves over time. It keeps per-state dwell counts, a transition count, a short history of distinct states, and a detector for the Gray-count-up walk 00→01→11→10. It sits directly on the A/B outputs and gives the lab bench a checkable summary instead of raw waveforms.

---
 rtl/ab_mon_pkg.sv | 10 +
 rtl/ab_trace_monitor_sat_counter.sv | 17 +
 rtl/ab_trace_monitor.sv | 68 ++++++
 3 files changed

// File: rtl/ab_mon_pkg.sv
// ab_mon_pkg: shared state constants, detector states and defaults for ab_trace_monitor
package ab_mon_pkg;
  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S10 = 2'b10;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_HIST_DEPTH = 4;
  typedef enum logic [1:0] {IDLE, G00, G01, G11} det_e;
endpackage

// File: rtl/ab_trace_monitor_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (clear) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
endmodule

// File: rtl/ab_trace_monitor.sv
// ab_trace_monitor: dwell/transition counters, state history and Gray-walk detector on {A,B}
module ab_trace_monitor
  import ab_mon_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int HIST_DEPTH = DEF_HIST_DEPTH
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    A,
  input  logic                    B,
  input  logic                    valid,
  input  logic [1:0]              sel,
  output logic [1:0]              cur_state,
  output logic [CNT_W-1:0]        dwell_cnt,
  output logic [CNT_W-1:0]        trans_cnt,
  output logic [2*HIST_DEPTH-1:0] hist,
  output logic                    seq_hit
);
  logic [1:0] s, cur_q, cur_d;
  logic seen_q, seen_d, hit_q, hit_d, first, chg, eval;
  logic [2*HIST_DEPTH-1:0] hist_q, hist_d;
  logic [CNT_W-1:0] dwell [4];
  det_e det_q, det_d;
  assign s = {A, B};
  assign first = valid && !seen_q;
  assign chg = valid && seen_q && s != cur_q;
  assign eval = first || chg;
  // any 00 restarts the walk, so every non-advancing step falls back to G00 or IDLE
  always_comb begin
    hit_d = eval && det_q == G11 && s == S10;
    det_d = !eval ? det_q :
            hit_d ? IDLE :
            (det_q == G00 && s == S01) ? G01 :
            (det_q == G01 && s == S11) ? G11 :
            (s == S00) ? G00 : IDLE;
    cur_d = eval ? s : cur_q;
    seen_d = seen_q || valid;
    hist_d = chg ? {hist_q[2*HIST_DEPTH-3:0], s} : hist_q;
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      cur_q <= S00;
      seen_q <= 1'b0;
      hit_q <= 1'b0;
      hist_q <= '0;
      det_q <= IDLE;
    end else begin
      cur_q <= cur_d;
      seen_q <= seen_d;
      hit_q <= hit_d;
      hist_q <= hist_d;
      det_q <= det_d;
    end
  end
  for (genvar i = 0; i < 4; i++) begin : g_dwell
    sat_counter #(.W(CNT_W)) u_dwell (
      .clk(clk), .clear(clear), .inc(valid && s == 2'(i)), .cnt(dwell[i])
    );
  end
  sat_counter #(.W(CNT_W)) u_trans (
    .clk(clk), .clear(clear), .inc(chg), .cnt(trans_cnt)
  );
  assign cur_state = cur_q;
  assign dwell_cnt = dwell[sel];
  assign hist = hist_q;
  assign seq_hit = hit_q;
endmodule
